// File: rtl/button_reader.sv
// Pushbutton front end: two-flop synchronizer, per-edge debounce FSM, and
// registered level / press / release / long-press strobes plus a press counter.
module button_reader #(
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int LONG_PRESS_CYCLES = 16,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press_pulse,
    output logic [7:0] press_count
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } state_t;

    logic              s1_q, s2_q;
    logic              p;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_done_q, long_done_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              rel_q, rel_d;
    logic              long_q, long_d;
    logic [7:0]        count_q, count_d;
    logic              held;

    // Synchronizer resets to the idle pin level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= ACTIVE_LOW;
            s2_q <= ACTIVE_LOW;
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
        end
    end

    assign p = s2_q ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RELEASED;
            cnt_q       <= '0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            rel_q       <= 1'b0;
            long_q      <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            long_q      <= long_d;
            count_q     <= count_d;
        end
    end

    // RELEASE_PEND still counts as held, so a long press can land on the release edge.
    assign held = (state_q == PRESSED) || (state_q == RELEASE_PEND);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        rel_d       = 1'b0;
        long_d      = 1'b0;
        count_d     = count_q;

        if (held && (hold_q != HOLD_MAX))
            hold_d = hold_q + 1'b1;
        if (held && (hold_d == HOLD_MAX) && !long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
        end

        case (state_q)
            RELEASED: begin
                if (p) begin
                    state_d = PRESS_PEND;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_PEND: begin
                if (!p) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    count_d     = count_q + 8'd1;
                    hold_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!p) begin
                    state_d = RELEASE_PEND;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_PEND: begin
                if (p) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn_level        = level_q;
    assign press_pulse      = press_q;
    assign release_pulse    = rel_q;
    assign long_press_pulse = long_q;
    assign press_count      = count_q;

endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader: stimulus queues expected events by cycle,
// a negedge monitor pops and compares whenever a strobe fires or a snapshot is due.
module tb_button_reader;

    localparam logic [2:0] M_PRESS = 3'b001;
    localparam logic [2:0] M_REL   = 3'b010;
    localparam logic [2:0] M_LONG  = 3'b100;
    localparam logic [2:0] M_NONE  = 3'b000;

    logic       clk;
    logic       rst_n;
    logic       btn_in;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press_pulse;
    logic [7:0] press_count;

    int cyc;
    bit done;
    int n_cmp;
    int n_err;

    typedef struct {
        int         at;
        logic [2:0] mask;
        logic       lvl;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    exp_t q[$];

    button_reader #(
        .DEBOUNCE_CYCLES(4),
        .LONG_PRESS_CYCLES(16),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_press_pulse(long_press_pulse),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [2:0] m, input int at, input logic l, input int c,
                        input string nm);
        exp_t e;
        int   idx;
        e.at   = at;
        e.mask = m;
        e.lvl  = l;
        e.cnt  = 8'(c);
        e.name = nm;
        idx    = q.size();
        while (idx > 0 && q[idx-1].at > at) idx--;
        q.insert(idx, e);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [2:0] obs;
        exp_t       e;
        obs = {long_press_pulse, release_pulse, press_pulse};
        while (q.size() > 0 && q[0].at < cyc) begin
            e = q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %s: never observed, want cyc=%0d mask=%b lvl=%b cnt=%0d",
                     e.name, e.at, e.mask, e.lvl, e.cnt);
        end
        if (obs != 3'b000 || (q.size() > 0 && q[0].at == cyc)) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected: cyc=%0d got mask=%b lvl=%b cnt=%0d, want no event",
                         cyc, obs, btn_level, press_count);
            end else begin
                e = q.pop_front();
                if (e.at != cyc || obs != e.mask || btn_level !== e.lvl || press_count !== e.cnt) begin
                    n_err++;
                    $display("FAIL %s: got cyc=%0d mask=%b lvl=%b cnt=%0d, want cyc=%0d mask=%b lvl=%b cnt=%0d",
                             e.name, cyc, obs, btn_level, press_count, e.at, e.mask, e.lvl, e.cnt);
                end
            end
        end
        if (done || cyc > 20000) begin
            if (!done) begin
                n_cmp++;
                n_err++;
                $display("FAIL timeout: cyc=%0d got stimulus unfinished, want done", cyc);
            end
            while (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL %s: left over, want cyc=%0d mask=%b", e.name, e.at, e.mask);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

    initial begin
        int n;
        n_cmp  = 0;
        n_err  = 0;
        done   = 1'b0;
        btn_in = 1'b1;
        rst_n  = 1'b0;

        // Reset and 50 idle cycles
        tick(2);
        push(M_NONE, cyc, 0, 0, "reset_state");
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) push(M_NONE, cyc + 10 * i, 0, 0, "idle");
        tick(50);

        // Clean press held 100 cycles: press, long 16 later, then release
        btn_in = 1'b0; n = cyc;
        push(M_PRESS, n + 6, 1, 1, "clean_press");
        push(M_LONG, n + 22, 1, 1, "long_press");
        push(M_NONE, n + 50, 1, 1, "held_level");
        tick(100);
        btn_in = 1'b1; n = cyc;
        push(M_REL, n + 6, 0, 1, "long_release");
        push(M_NONE, n + 10, 0, 1, "released_level");
        tick(12);

        // Bounce while released: 3 low / 3 high, five times
        repeat (5) begin
            btn_in = 1'b0; tick(3);
            btn_in = 1'b1; tick(3);
        end
        push(M_NONE, cyc + 4, 0, 1, "bounce_released");
        tick(8);

        // Bounce while pressed: 3-cycle high glitch must not release
        btn_in = 1'b0; n = cyc;
        push(M_PRESS, n + 6, 1, 2, "press2");
        push(M_LONG, n + 22, 1, 2, "long2");
        tick(8);
        btn_in = 1'b1; tick(3);
        btn_in = 1'b0;
        push(M_NONE, cyc + 6, 1, 2, "bounce_pressed");
        tick(30);
        btn_in = 1'b1; n = cyc;
        push(M_REL, n + 6, 0, 2, "release2");
        tick(10);

        // Short press: release commits 10 cycles after press commit, no long
        btn_in = 1'b0; n = cyc;
        push(M_PRESS, n + 6, 1, 3, "short_press");
        tick(10);
        btn_in = 1'b1;
        push(M_REL, n + 16, 0, 3, "short_release");
        push(M_NONE, n + 30, 0, 3, "after_short");
        tick(30);

        // Long threshold lands exactly on the release-commit edge
        btn_in = 1'b0; n = cyc;
        push(M_PRESS, n + 6, 1, 4, "coinc_press");
        tick(16);
        btn_in = 1'b1;
        push(M_LONG | M_REL, n + 22, 0, 4, "long_and_release");
        tick(30);

        // Reset, then 256 presses wrap the counter to 0
        rst_n = 1'b0;
        push(M_NONE, cyc, 0, 0, "reset_clear");
        tick(2);
        rst_n = 1'b1;
        tick(2);
        for (int k = 1; k <= 256; k++) begin
            btn_in = 1'b0; n = cyc;
            push(M_PRESS, n + 6, 1, k % 256, "wrap_press");
            tick(8);
            btn_in = 1'b1;
            push(M_REL, n + 14, 0, k % 256, "wrap_release");
            tick(6);
        end
        push(M_NONE, cyc + 2, 0, 0, "wrapped_count");
        tick(4);

        // Reset mid-press with the button still held
        btn_in = 1'b0; n = cyc;
        push(M_PRESS, n + 6, 1, 1, "pre_reset_press");
        tick(10);
        rst_n = 1'b0;
        push(M_NONE, cyc, 0, 0, "async_reset");
        tick(3);
        rst_n = 1'b1; n = cyc;
        push(M_PRESS, n + 6, 1, 1, "redetect_press");
        push(M_LONG, n + 22, 1, 1, "redetect_long");
        tick(30);
        btn_in = 1'b1; n = cyc;
        push(M_REL, n + 6, 0, 1, "redetect_release");
        tick(12);

        done = 1'b1;
    end

endmodule
